// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage in front of the program ROM. Owns the
//               PC, runs the extra data-read cycle for ROM data opcodes and
//               hands the instruction to execute over valid/ready. Optional
//               halt-on-0xFFFF behaviour is enabled by FETCH_HALT_OPCODE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ROM_DEPTH  = 256,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] rom_addr,
    output logic                  rom_enable,
    output logic                  rom_read_data_enable,
    input  logic [DATA_WIDTH-1:0] rom_opcode,
    input  logic [DATA_WIDTH-1:0] rom_operand,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  jump_valid,
    input  logic [DATA_WIDTH-1:0] jump_target,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_operand,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic                  halted
);

    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_DATA  = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;
    localparam logic [1:0] c_HALT  = 2'd3;

    // ROM_DEPTH is a power of two, so masking implements the modulo.
    localparam logic [DATA_WIDTH-1:0] c_PC_MASK = DATA_WIDTH'(ROM_DEPTH - 1);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
    logic [DATA_WIDTH-1:0] iop_q, iop_d;
    logic [DATA_WIDTH-1:0] iopnd_q, iopnd_d;
    logic [DATA_WIDTH-1:0] idata_q, idata_d;
    logic                  halted_q, halted_d;
    logic                  is_data_op;

    assign is_data_op = (rom_opcode[15:8] == 8'h31) || (rom_opcode[15:8] == 8'h32);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        ipc_d    = ipc_q;
        iop_d    = iop_q;
        iopnd_d  = iopnd_q;
        idata_d  = idata_q;
        halted_d = halted_q;
        if (jump_valid) begin
            pc_d     = jump_target & c_PC_MASK;
            state_d  = c_FETCH;
            valid_d  = 1'b0;
            halted_d = 1'b0;
        end else begin
            case (state_q)
                c_FETCH: begin
                    ipc_d   = pc_q;
                    iop_d   = rom_opcode;
                    iopnd_d = rom_operand;
                    if (is_data_op) begin
                        state_d = c_DATA;
`ifdef FETCH_HALT_OPCODE_EN
                    end else if (rom_opcode == 16'hFFFF) begin
                        // The halt word is captured but never presented.
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                        state_d  = c_HALT;
`endif
                    end else begin
                        idata_d = '0;
                        valid_d = 1'b1;
                        state_d = c_HOLD;
                    end
                end
                c_DATA: begin
                    idata_d = rom_data;
                    valid_d = 1'b1;
                    state_d = c_HOLD;
                end
                c_HOLD: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        pc_d    = (pc_q + DATA_WIDTH'(1)) & c_PC_MASK;
                        state_d = c_FETCH;
                    end
                end
`ifdef FETCH_HALT_OPCODE_EN
                c_HALT: begin
                    state_d = c_HALT;
                end
`endif
                default: begin
                    state_d = c_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_FETCH;
            pc_q     <= RESET_PC & c_PC_MASK;
            valid_q  <= 1'b0;
            ipc_q    <= '0;
            iop_q    <= '0;
            iopnd_q  <= '0;
            idata_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            ipc_q    <= ipc_d;
            iop_q    <= iop_d;
            iopnd_q  <= iopnd_d;
            idata_q  <= idata_d;
            halted_q <= halted_d;
        end
    end

    assign rom_addr             = pc_q;
    assign rom_enable           = (state_q == c_FETCH) || (state_q == c_DATA);
    assign rom_read_data_enable = (state_q == c_DATA);
    assign instr_valid          = valid_q;
    assign instr_pc             = ipc_q;
    assign instr_opcode         = iop_q;
    assign instr_operand        = iopnd_q;
    assign instr_data           = idata_q;
`ifdef FETCH_HALT_OPCODE_EN
    assign halted               = halted_q;
`else
    assign halted               = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] rom_addr;
    logic        rom_enable;
    logic        rom_read_data_enable;
    logic [15:0] rom_opcode;
    logic [15:0] rom_operand;
    logic [15:0] rom_data;
    logic        jump_valid;
    logic [15:0] jump_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_pc;
    logic [15:0] instr_opcode;
    logic [15:0] instr_operand;
    logic [15:0] instr_data;
    logic        halted;

    logic [31:0] rom_mem [256];
    int          pass_cnt;
    int          total_cnt;

    fetch_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .rom_addr             (rom_addr),
        .rom_enable           (rom_enable),
        .rom_read_data_enable (rom_read_data_enable),
        .rom_opcode           (rom_opcode),
        .rom_operand          (rom_operand),
        .rom_data             (rom_data),
        .jump_valid           (jump_valid),
        .jump_target          (jump_target),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .instr_pc             (instr_pc),
        .instr_opcode         (instr_opcode),
        .instr_operand        (instr_operand),
        .instr_data           (instr_data),
        .halted               (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: the data read uses the captured operand as the data word address.
    assign rom_opcode  = rom_mem[rom_addr[7:0]][31:16];
    assign rom_operand = rom_mem[rom_addr[7:0]][15:0];
    assign rom_data    = rom_read_data_enable ? rom_mem[instr_operand[7:0]][15:0] : 16'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; jump_valid = 1'b0; jump_target = 16'h0; instr_ready = 1'b1;
        tick(); tick();
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else pass_cnt++;
        total_cnt++; if (rom_addr !== 16'h0) $display("FAIL rst_addr: got %h want 0000", rom_addr); else pass_cnt++;
        total_cnt++; if (rom_enable !== 1'b1) $display("FAIL rst_en: got %b want 1", rom_enable); else pass_cnt++;
        total_cnt++; if (rom_read_data_enable !== 1'b0) $display("FAIL rst_rde: got %b want 0", rom_read_data_enable); else pass_cnt++;
        total_cnt++; if ({instr_pc, instr_opcode, instr_operand, instr_data} !== 64'h0)
            $display("FAIL rst_instr: got %h want 0", {instr_pc, instr_opcode, instr_operand, instr_data}); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_plain();
        tick();
        total_cnt++; if (instr_valid !== 1'b1) $display("FAIL plain_valid: got %b want 1", instr_valid); else pass_cnt++;
        total_cnt++; if ({instr_pc, instr_opcode, instr_operand, instr_data} !== 64'h0000_0100_0005_0000)
            $display("FAIL plain_bundle: got %h want 0000010000050000", {instr_pc, instr_opcode, instr_operand, instr_data}); else pass_cnt++;
        total_cnt++; if (rom_enable !== 1'b0) $display("FAIL plain_hold_en: got %b want 0", rom_enable); else pass_cnt++;
        tick();
        total_cnt++; if (rom_addr !== 16'h0001) $display("FAIL plain_next_addr: got %h want 0001", rom_addr); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL plain_consumed: got %b want 0", instr_valid); else pass_cnt++;
    endtask

    task automatic test_data();
        instr_ready = 1'b0; jump_valid = 1'b1; jump_target = 16'h0003;
        tick();
        jump_valid = 1'b0;
        total_cnt++; if (rom_addr !== 16'h0003) $display("FAIL data_addr: got %h want 0003", rom_addr); else pass_cnt++;
        total_cnt++; if (rom_read_data_enable !== 1'b0) $display("FAIL data_rde_fetch: got %b want 0", rom_read_data_enable); else pass_cnt++;
        tick();
        total_cnt++; if (rom_read_data_enable !== 1'b1) $display("FAIL data_rde: got %b want 1", rom_read_data_enable); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL data_early_valid: got %b want 0", instr_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rom_read_data_enable !== 1'b0) $display("FAIL data_rde_off: got %b want 0", rom_read_data_enable); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b1) $display("FAIL data_valid: got %b want 1", instr_valid); else pass_cnt++;
        total_cnt++; if ({instr_pc, instr_opcode, instr_operand, instr_data} !== 64'h0003_3100_0010_ABCD)
            $display("FAIL data_bundle: got %h want 000331000010abcd", {instr_pc, instr_opcode, instr_operand, instr_data}); else pass_cnt++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if ({instr_valid, instr_pc, instr_opcode, instr_data} !== 49'h1_0003_3100_ABCD)
                $display("FAIL stall_bundle[%0d]: got %h want 1000331 00abcd", i, {instr_valid, instr_pc, instr_opcode, instr_data}); else pass_cnt++;
            total_cnt++; if ({rom_enable, rom_addr} !== 17'h0_0003)
                $display("FAIL stall_rom[%0d]: got %h want 00003", i, {rom_enable, rom_addr}); else pass_cnt++;
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total_cnt++; if ({rom_enable, rom_addr} !== 17'h1_0004) $display("FAIL stall_next: got %h want 10004", {rom_enable, rom_addr}); else pass_cnt++;
        tick();
        total_cnt++; if ({instr_valid, instr_pc, instr_opcode, instr_data} !== 49'h1_0004_0400_0000)
            $display("FAIL stall_after: got %h want 1000404000000", {instr_valid, instr_pc, instr_opcode, instr_data}); else pass_cnt++;
    endtask

    task automatic test_jump();
        instr_ready = 1'b1; jump_valid = 1'b1; jump_target = 16'h0140;
        tick();
        instr_ready = 1'b0; jump_valid = 1'b0;
        total_cnt++; if (rom_addr !== 16'h0040) $display("FAIL jump_addr: got %h want 0040", rom_addr); else pass_cnt++;
        total_cnt++; if (instr_valid !== 1'b0) $display("FAIL jump_valid_low: got %b want 0", instr_valid); else pass_cnt++;
        tick();
        total_cnt++; if ({instr_valid, instr_pc, instr_opcode} !== 33'h1_0040_0500)
            $display("FAIL jump_bundle: got %h want 100400500", {instr_valid, instr_pc, instr_opcode}); else pass_cnt++;
    endtask

    task automatic test_wrap();
        jump_valid = 1'b1; jump_target = 16'h00FF;
        tick();
        jump_valid = 1'b0;
        tick();
        total_cnt++; if ({instr_valid, instr_pc, instr_opcode} !== 33'h1_00FF_0600)
            $display("FAIL wrap_bundle: got %h want 100ff0600", {instr_valid, instr_pc, instr_opcode}); else pass_cnt++;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total_cnt++; if ({rom_enable, rom_addr} !== 17'h1_0000) $display("FAIL wrap_addr: got %h want 10000", {rom_enable, rom_addr}); else pass_cnt++;
    endtask

    task automatic test_reset_in_data();
        jump_valid = 1'b1; jump_target = 16'h0003;
        tick();
        jump_valid = 1'b0;
        tick();
        total_cnt++; if (rom_read_data_enable !== 1'b1) $display("FAIL rstdata_in_data: got %b want 1", rom_read_data_enable); else pass_cnt++;
        rst = 1'b1; jump_valid = 1'b1; jump_target = 16'h0005;
        tick();
        rst = 1'b0; jump_valid = 1'b0;
        total_cnt++; if ({instr_valid, rom_read_data_enable, rom_addr} !== 18'h0_0000)
            $display("FAIL rstdata_state: got %h want 00000", {instr_valid, rom_read_data_enable, rom_addr}); else pass_cnt++;
    endtask

    task automatic test_jump_in_data();
        jump_valid = 1'b1; jump_target = 16'h0003;
        tick();
        tick();
        jump_target = 16'h0000;
        tick();
        jump_valid = 1'b0;
        total_cnt++; if ({instr_valid, rom_read_data_enable, rom_addr} !== 18'h0_0000)
            $display("FAIL jdata_redirect: got %h want 00000", {instr_valid, rom_read_data_enable, rom_addr}); else pass_cnt++;
        tick();
        total_cnt++; if ({instr_valid, instr_opcode, instr_data} !== 33'h1_0100_0000)
            $display("FAIL jdata_bundle: got %h want 101000000", {instr_valid, instr_opcode, instr_data}); else pass_cnt++;
    endtask

    task automatic test_halt();
        jump_valid = 1'b1; jump_target = 16'h0007;
        tick();
        jump_valid = 1'b0;
        tick();
`ifdef FETCH_HALT_OPCODE_EN
        total_cnt++; if ({halted, instr_valid, rom_enable} !== 3'b100)
            $display("FAIL halt_enter: got %b want 100", {halted, instr_valid, rom_enable}); else pass_cnt++;
        tick();
        total_cnt++; if ({halted, rom_enable, rom_addr} !== 18'h2_0007)
            $display("FAIL halt_frozen: got %h want 20007", {halted, rom_enable, rom_addr}); else pass_cnt++;
        jump_valid = 1'b1; jump_target = 16'h0002;
        tick();
        jump_valid = 1'b0;
        total_cnt++; if ({halted, rom_enable, rom_addr} !== 18'h1_0002)
            $display("FAIL halt_exit: got %h want 10002", {halted, rom_enable, rom_addr}); else pass_cnt++;
        tick();
        total_cnt++; if ({instr_valid, instr_pc, instr_opcode} !== 33'h1_0002_0300)
            $display("FAIL halt_resume: got %h want 100020300", {instr_valid, instr_pc, instr_opcode}); else pass_cnt++;
`else
        total_cnt++; if ({halted, instr_valid, instr_pc, instr_opcode} !== 34'h1_0007_FFFF)
            $display("FAIL nohalt_bundle: got %h want 10007ffff", {halted, instr_valid, instr_pc, instr_opcode}); else pass_cnt++;
`endif
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst = 1'b1; jump_valid = 1'b0; jump_target = 16'h0; instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'h0;
        rom_mem[0]   = 32'h0100_0005;
        rom_mem[1]   = 32'h0200_0006;
        rom_mem[2]   = 32'h0300_0007;
        rom_mem[3]   = 32'h3100_0010;
        rom_mem[4]   = 32'h0400_0008;
        rom_mem[7]   = 32'hFFFF_0000;
        rom_mem[16]  = 32'h0000_ABCD;
        rom_mem[64]  = 32'h0500_0009;
        rom_mem[255] = 32'h0600_000A;
        test_reset();
        test_plain();
        test_data();
        test_stall();
        test_jump();
        test_wrap();
        test_reset_in_data();
        test_jump_in_data();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
